// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART byte transmitter between NUM_REQ requesters using round-robin,
// message-granular grants bounded by a per-grant byte budget and an idle-hold timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_MSG      = 16,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy
);
    localparam int               IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]       BYTE_LIMIT = 8'(MAX_MSG - 1);
    localparam logic [9:0]       HOLD_LIMIT = 10'(HOLD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_GRANT     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;
    logic [9:0]         hold_cnt_q, hold_cnt_d;
    logic               last_q, last_d;

    logic               win_found_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [NUM_REQ-1:0] win_onehot_s;
    logic [7:0]         owner_byte_s;
    logic               owner_req_s;
    logic               owner_last_s;

    // First requester found scanning ptr+1, ptr+2, ... wrapping; returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand  = IDX_W'((int'(ptr) + off) % NUM_REQ);
            idx   = (r[cand] && !found) ? cand : idx;
            found = found | r[cand];
        end
        return {found, idx};
    endfunction

    // Round-robin winner candidate and owner-side input selection.
    always_comb begin
        {win_found_s, win_idx_s} = rr_pick(req, rr_ptr_q);
        win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
        owner_req_s  = req[owner_q];
        owner_last_s = req_last[owner_q];
        owner_byte_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_byte_s = owner_byte_s | (req_data[8*i +: 8] & {8{owner_q == IDX_W'(i)}});
        end
    end

    // Arbitration FSM: next state, counters and registered-output next values.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        req_ack_d  = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        byte_cnt_d = byte_cnt_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (win_found_s) begin
                    state_d    = S_GRANT;
                    owner_d    = win_idx_s;
                    gnt_d      = win_onehot_s;
                    byte_cnt_d = 8'd0;
                    hold_cnt_d = 10'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (owner_req_s) begin
                    state_d    = S_WAIT_BUSY;
                    tx_start_d = 1'b1;
                    tx_data_d  = owner_byte_s;
                    req_ack_d  = gnt_q;
                    last_d     = owner_last_s | (byte_cnt_q == BYTE_LIMIT);
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    hold_cnt_d = 10'd0;
                end else if (hold_cnt_q == HOLD_LIMIT) begin
                    // Owner went quiet without finishing: hand the line back.
                    state_d  = S_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = owner_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + 10'd1;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        state_d  = S_IDLE;
                        gnt_d    = '0;
                        rr_ptr_d = owner_q;
                    end else begin
                        state_d    = S_GRANT;
                        hold_cnt_d = 10'd0;
                    end
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            req_ack_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rr_ptr_q   <= LAST_IDX;
            owner_q    <= '0;
            byte_cnt_q <= 8'd0;
            hold_cnt_q <= 10'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            req_ack_q  <= req_ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            byte_cnt_q <= byte_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    assign gnt      = gnt_q;
    assign req_ack  = req_ack_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a 3-cycle transmitter model
// are stepped on the falling edge; expectations are hand-computed constants.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int MAX_MSG      = 16;
    localparam int HOLD_TIMEOUT = 64;
    localparam int BUSY_LEN     = 3;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .MAX_MSG(MAX_MSG), .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .gnt(gnt), .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int cycle_n = 0;
    int busy_left = 0;
    bit model_on = 1'b0;
    logic [NUM_REQ-1:0] prev_gnt = '0;

    logic [7:0] mem [NUM_REQ][32];
    logic       lst [NUM_REQ][32];
    int         len [NUM_REQ];
    int         pos [NUM_REQ];

    int log_own[$];
    int log_dat[$];
    int log_cyc[$];
    int grant_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i] === 1'b1) r = i;
        return r;
    endfunction

    function automatic int dat_at(input int k);
        return (k < log_dat.size()) ? log_dat[k] : -1;
    endfunction

    function automatic int own_at(input int k);
        return (k < log_own.size()) ? log_own[k] : -1;
    endfunction

    function automatic int cyc_at(input int k);
        return (k < log_cyc.size()) ? log_cyc[k] : -1;
    endfunction

    function automatic int grant_at(input int k);
        return (k < grant_log.size()) ? grant_log[k] : -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += len[i] - pos[i];
        return s;
    endfunction

    task automatic clear_logs();
        log_own.delete();
        log_dat.delete();
        log_cyc.delete();
        grant_log.delete();
    endtask

    task automatic add_msg(input int i, input logic [7:0] first, input int n, input bit last_end);
        for (int k = 0; k < n; k++) begin
            mem[i][len[i]] = first + 8'(k);
            lst[i][len[i]] = last_end && (k == n - 1);
            len[i]++;
        end
    endtask

    task automatic drive_req();
        if (model_on) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pos[i] < len[i]) begin
                    req[i]             = 1'b1;
                    req_data[8*i +: 8] = mem[i][pos[i]];
                    req_last[i]        = lst[i][pos[i]];
                end else begin
                    req[i]             = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    endtask

    // One clock: sample at the falling edge, advance transmitter and requester models.
    task automatic cyc();
        @(negedge clk);
        cycle_n++;
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("ack_only_owner", 32'(req_ack & ~gnt), 32'd0);
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end
        if (tx_start === 1'b1) begin
            tx_busy   = 1'b1;
            busy_left = BUSY_LEN;
            log_own.push_back(oh_idx(gnt));
            log_dat.push_back(int'(tx_data));
            log_cyc.push_back(cycle_n);
        end
        if (gnt !== '0 && prev_gnt === '0) grant_log.push_back(oh_idx(gnt));
        prev_gnt = gnt;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack[i] === 1'b1 && pos[i] < len[i]) pos[i]++;
        end
        drive_req();
    endtask

    task automatic wait_tx(input int n, input int limit, input string tag);
        int k = 0;
        while (log_dat.size() < n && k < limit) begin cyc(); k++; end
        check(tag, 32'(log_dat.size()), 32'(n));
    endtask

    task automatic wait_gnt_zero(input int limit, input string tag);
        int k = 0;
        while (gnt !== '0 && k < limit) begin cyc(); k++; end
        check(tag, 32'(gnt), 32'd0);
    endtask

    task automatic wait_drained(input int limit, input string tag);
        int k = 0;
        while ((pending() != 0 || gnt !== '0) && k < limit) begin cyc(); k++; end
        check({tag, "_pending"}, 32'(pending()), 32'd0);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int exp_g [6];
        int exp_d [6];
        int ed;
        int eo;

        rst = 1'b1; req = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin len[i] = 0; pos[i] = 0; end

        // 1: reset held with every requester asserting
        req = 4'hF; req_data = 32'h44434241; req_last = 4'hF;
        repeat (3) begin
            cyc();
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_tx_start", 32'(tx_start), 32'd0);
            check("rst_req_ack", 32'(req_ack), 32'd0);
        end
        check("rst_tx_data", 32'(tx_data), 32'h00);
        req = '0; req_data = '0; req_last = '0;
        model_on = 1'b1;
        rst = 1'b0;
        clear_logs();

        // 2: single 3-byte message from requester 0
        add_msg(0, 8'h41, 3, 1'b1);
        drive_req();
        cyc();
        check("t2_gnt", 32'(gnt), 32'b0001);
        check("t2_no_start_yet", 32'(tx_start), 32'd0);
        cyc();
        check("t2_start", 32'(tx_start), 32'd1);
        check("t2_first_data", 32'(tx_data), 32'h41);
        check("t2_ack", 32'(req_ack), 32'b0001);
        wait_gnt_zero(100, "t2_release");
        c0 = cycle_n;
        check("t2_count", 32'(log_dat.size()), 32'd3);
        check("t2_b0", 32'(dat_at(0)), 32'h41);
        check("t2_b1", 32'(dat_at(1)), 32'h42);
        check("t2_b2", 32'(dat_at(2)), 32'h43);
        check("t2_owner", 32'(own_at(2)), 32'd0);
        check("t2_gap1", 32'(cyc_at(1) - cyc_at(0)), 32'd5);
        check("t2_gap2", 32'(cyc_at(2) - cyc_at(0)), 32'd10);
        check("t2_release_cycle", 32'(c0 - cyc_at(2)), 32'd4);
        check("t2_data_hold", 32'(tx_data), 32'h43);

        // 3: round-robin among requesters 0, 1 and 3 from a fresh reset
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        clear_logs();
        add_msg(0, 8'hA0, 1, 1'b1); add_msg(1, 8'hB0, 1, 1'b1); add_msg(3, 8'hD0, 1, 1'b1);
        add_msg(0, 8'hA1, 1, 1'b1); add_msg(1, 8'hB1, 1, 1'b1); add_msg(3, 8'hD1, 1, 1'b1);
        drive_req();
        wait_drained(300, "t3_drain");
        exp_g = '{0, 1, 3, 0, 1, 3};
        exp_d = '{32'hA0, 32'hB0, 32'hD0, 32'hA1, 32'hB1, 32'hD1};
        check("t3_grants", 32'(grant_log.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t3_grant%0d", k), 32'(grant_at(k)), 32'(exp_g[k]));
            check($sformatf("t3_data%0d", k), 32'(dat_at(k)), 32'(exp_d[k]));
        end

        // 4: byte budget forces requester 2 off after 16 bytes
        clear_logs();
        add_msg(2, 8'h80, 20, 1'b0);
        drive_req();
        cyc();
        check("t4_gnt2", 32'(gnt), 32'b0100);
        add_msg(1, 8'h51, 2, 1'b1);
        wait_drained(600, "t4_drain");
        check("t4_count", 32'(log_dat.size()), 32'd22);
        check("t4_grants", 32'(grant_log.size()), 32'd3);
        check("t4_grant0", 32'(grant_at(0)), 32'd2);
        check("t4_grant1", 32'(grant_at(1)), 32'd1);
        check("t4_grant2", 32'(grant_at(2)), 32'd2);
        for (int k = 0; k < 22; k++) begin
            ed = (k < 16) ? (32'h80 + k) : (k < 18) ? (32'h51 + k - 16) : (32'h80 + k - 2);
            eo = (k < 16 || k >= 18) ? 2 : 1;
            check($sformatf("t4_data%0d", k), 32'(dat_at(k)), 32'(ed));
            check($sformatf("t4_owner%0d", k), 32'(own_at(k)), 32'(eo));
        end

        // 5: requester 1 stalls after one unfinished byte
        clear_logs();
        add_msg(1, 8'h61, 1, 1'b0);
        drive_req();
        wait_tx(1, 20, "t5_first");
        check("t5_owner", 32'(own_at(0)), 32'd1);
        c1 = cyc_at(0);
        add_msg(0, 8'h71, 1, 1'b1);
        wait_gnt_zero(200, "t5_release");
        check("t5_timeout_cycle", 32'(cycle_n - c1), 32'(4 + HOLD_TIMEOUT));
        cyc();
        check("t5_next_gnt0", 32'(gnt), 32'b0001);
        wait_drained(100, "t5_drain");
        check("t5_data1", 32'(dat_at(1)), 32'h71);
        check("t5_owner1", 32'(own_at(1)), 32'd0);

        // 6: reset while requester 3 waits for its first byte to finish
        clear_logs();
        add_msg(3, 8'hD1, 3, 1'b1);
        drive_req();
        wait_tx(1, 20, "t6_first");
        check("t6_owner", 32'(own_at(0)), 32'd3);
        cyc();
        rst = 1'b1;
        add_msg(0, 8'h0A, 1, 1'b1);
        drive_req();
        repeat (3) begin
            cyc();
            check("t6_rst_gnt", 32'(gnt), 32'd0);
            check("t6_rst_tx_start", 32'(tx_start), 32'd0);
            check("t6_rst_req_ack", 32'(req_ack), 32'd0);
        end
        rst = 1'b0;
        cyc();
        check("t6_req0_wins", 32'(gnt), 32'b0001);
        wait_drained(200, "t6_drain");
        check("t6_count", 32'(log_dat.size()), 32'd4);
        check("t6_d1", 32'(dat_at(1)), 32'h0A);
        check("t6_o1", 32'(own_at(1)), 32'd0);
        check("t6_d2", 32'(dat_at(2)), 32'hD2);
        check("t6_o2", 32'(own_at(2)), 32'd3);
        check("t6_d3", 32'(dat_at(3)), 32'hD3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
